// File: rtl/id_ex_latch_if.sv
// rtl/id_ex_latch_if.sv - shared types and decode-to-execute pipeline bus for id_ex_latch
//
// id_ex_pkg   : word_t (32-bit datapath word), aluop_t (ALU operation codes)
// id_ex_latch_if ports:
//   control  : en (advance, 0 = stall), flush (squash incoming instruction)
//   decode   : id_valid, id_rdat1, id_rdat2, id_imm16, id_shamt, id_aluop,
//              id_alusrc, id_shift, id_wsel, id_regwen
//   execute  : portA, portB, aluop (ALU inputs), ex_valid, ex_regwen,
//              ex_wsel, ex_stdat (store data)
//   perf     : stall_cnt
// modport master drives the decode/control side, modport slave is the latch.

package id_ex_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

interface id_ex_latch_if;
    import id_ex_pkg::*;

    logic        en;
    logic        flush;
    logic        id_valid;
    word_t       id_rdat1;
    word_t       id_rdat2;
    logic [15:0] id_imm16;
    logic [4:0]  id_shamt;
    aluop_t      id_aluop;
    logic [1:0]  id_alusrc;
    logic        id_shift;
    logic [4:0]  id_wsel;
    logic        id_regwen;

    word_t       portA;
    word_t       portB;
    aluop_t      aluop;
    logic        ex_valid;
    logic        ex_regwen;
    logic [4:0]  ex_wsel;
    word_t       ex_stdat;
    logic [15:0] stall_cnt;

    modport master (
        output en, flush, id_valid, id_rdat1, id_rdat2, id_imm16, id_shamt,
               id_aluop, id_alusrc, id_shift, id_wsel, id_regwen,
        input  portA, portB, aluop, ex_valid, ex_regwen, ex_wsel, ex_stdat,
               stall_cnt
    );

    modport slave (
        input  en, flush, id_valid, id_rdat1, id_rdat2, id_imm16, id_shamt,
               id_aluop, id_alusrc, id_shift, id_wsel, id_regwen,
        output portA, portB, aluop, ex_valid, ex_regwen, ex_wsel, ex_stdat,
               stall_cnt
    );
endinterface

// File: rtl/id_ex_latch.sv
// rtl/id_ex_latch.sv - ID/EX pipeline register with operand selection and stall counter
//
// Ports:
//   CLK   : system clock, all state updates on the rising edge
//   nRST  : asynchronous active-low reset
//   bus   : id_ex_latch_if.slave (control, decode inputs, execute outputs)
// Optional feature macro: ID_EX_PERF_EN enables the saturating 16-bit
// stall_cnt; when undefined stall_cnt is tied to zero.
// Priority on each edge: flush, then en (capture), otherwise hold.

module id_ex_latch
    import id_ex_pkg::*;
(
    input  logic          CLK,
    input  logic          nRST,
    id_ex_latch_if.slave  bus
);

    word_t      porta_d, porta_q;
    word_t      portb_d, portb_q;
    word_t      stdat_d, stdat_q;
    aluop_t     aluop_d, aluop_q;
    logic       valid_d, valid_q;
    logic       regwen_d, regwen_q;
    logic [4:0] wsel_d, wsel_q;

    // Operand selection; shift instructions override the B-operand select.
    always_comb begin
        porta_d  = bus.id_rdat1;
        portb_d  = bus.id_rdat2;
        stdat_d  = bus.id_rdat2;
        aluop_d  = bus.id_aluop;
        valid_d  = bus.id_valid;
        regwen_d = bus.id_regwen & bus.id_valid;   // a bubble never writes
        wsel_d   = bus.id_wsel;
        if (bus.id_shift) begin
            porta_d = bus.id_rdat2;
            portb_d = {27'd0, bus.id_shamt};
        end else begin
            unique case (bus.id_alusrc)
                2'd0:    portb_d = bus.id_rdat2;
                2'd1:    portb_d = {{16{bus.id_imm16[15]}}, bus.id_imm16};
                2'd2:    portb_d = {16'd0, bus.id_imm16};
                default: portb_d = {bus.id_imm16, 16'd0};
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            porta_q  <= '0;
            portb_q  <= '0;
            stdat_q  <= '0;
            aluop_q  <= ALU_SLL;
            valid_q  <= 1'b0;
            regwen_q <= 1'b0;
            wsel_q   <= '0;
        end else if (bus.flush) begin
            porta_q  <= '0;
            portb_q  <= '0;
            stdat_q  <= '0;
            aluop_q  <= ALU_SLL;
            valid_q  <= 1'b0;
            regwen_q <= 1'b0;
            wsel_q   <= '0;
        end else if (bus.en) begin
            porta_q  <= porta_d;
            portb_q  <= portb_d;
            stdat_q  <= stdat_d;
            aluop_q  <= aluop_d;
            valid_q  <= valid_d;
            regwen_q <= regwen_d;
            wsel_q   <= wsel_d;
        end
    end

    assign bus.portA     = porta_q;
    assign bus.portB     = portb_q;
    assign bus.ex_stdat  = stdat_q;
    assign bus.aluop     = aluop_q;
    assign bus.ex_valid  = valid_q;
    assign bus.ex_regwen = regwen_q;
    assign bus.ex_wsel   = wsel_q;

`ifdef ID_EX_PERF_EN
    logic [15:0] cnt_d, cnt_q;

    // Counts only cycles where a real instruction is held back by a stall.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.en && !bus.flush && valid_q && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bus.stall_cnt = cnt_q;
`else
    assign bus.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// tb/tb_id_ex_latch.sv - self-checking bench for id_ex_latch

module tb_id_ex_latch;
    import id_ex_pkg::*;

    logic CLK;
    logic nRST;
    int   ncmp;
    int   nfail;

    id_ex_latch_if bus ();

    id_ex_latch dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected architectural state of the EX stage.
    logic [31:0] exp_a, exp_b, exp_stdat;
    aluop_t      exp_op;
    logic        exp_valid, exp_regwen;
    logic [4:0]  exp_wsel;
    int          exp_cnt;

    task automatic model_reset();
        exp_a = 0; exp_b = 0; exp_stdat = 0; exp_op = ALU_SLL;
        exp_valid = 0; exp_regwen = 0; exp_wsel = 0; exp_cnt = 0;
    endtask

    // Applies the pipeline-register rules for one rising edge to the model.
    task automatic model_edge();
        logic [31:0] imm;
        imm = {16'd0, bus.id_imm16};
`ifdef ID_EX_PERF_EN
        if (!bus.en && !bus.flush && exp_valid && exp_cnt < 65535)
            exp_cnt = exp_cnt + 1;
`endif
        if (bus.flush) begin
            exp_a = 0; exp_b = 0; exp_stdat = 0; exp_op = ALU_SLL;
            exp_valid = 0; exp_regwen = 0; exp_wsel = 0;
        end else if (bus.en) begin
            exp_valid  = bus.id_valid;
            exp_regwen = bus.id_valid && bus.id_regwen;
            exp_wsel   = bus.id_wsel;
            exp_op     = bus.id_aluop;
            exp_stdat  = bus.id_rdat2;
            if (bus.id_shift) begin
                exp_a = bus.id_rdat2;
                exp_b = 32'(bus.id_shamt);
            end else begin
                exp_a = bus.id_rdat1;
                case (bus.id_alusrc)
                    2'd0: exp_b = bus.id_rdat2;
                    2'd1: exp_b = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
                    2'd2: exp_b = imm;
                    default: exp_b = imm * 65536;
                endcase
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic drive_random();
        bus.id_valid  = 1'($urandom);
        bus.id_rdat1  = $urandom;
        bus.id_rdat2  = $urandom;
        bus.id_imm16  = 16'($urandom);
        bus.id_shamt  = 5'($urandom);
        bus.id_aluop  = aluop_t'($urandom_range(0, 9));
        bus.id_alusrc = 2'($urandom);
        bus.id_shift  = ($urandom_range(0, 3) == 0);
        bus.id_wsel   = 5'($urandom);
        bus.id_regwen = 1'($urandom);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        model_reset();
        #2;
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.en = 1'b1; bus.flush = 1'b0;
        drive_random();
        model_reset();
        #12;
        ncmp++; if (bus.portA !== 32'd0) begin nfail++; $display("FAIL reset_portA got %h want 0", bus.portA); end
        ncmp++; if (bus.portB !== 32'd0) begin nfail++; $display("FAIL reset_portB got %h want 0", bus.portB); end
        ncmp++; if (bus.aluop !== ALU_SLL) begin nfail++; $display("FAIL reset_aluop got %0d want %0d", bus.aluop, ALU_SLL); end
        ncmp++; if ({bus.ex_valid, bus.ex_regwen, bus.ex_wsel} !== 7'd0) begin nfail++; $display("FAIL reset_ctl got %b%b%h want 0", bus.ex_valid, bus.ex_regwen, bus.ex_wsel); end
        ncmp++; if (bus.ex_stdat !== 32'd0 || bus.stall_cnt !== 16'd0) begin nfail++; $display("FAIL reset_stdat_cnt got %h/%h want 0/0", bus.ex_stdat, bus.stall_cnt); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_capture();
        drive_random();
        bus.en = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b1; bus.id_shift = 1'b0;
        bus.id_rdat1 = 32'h0000_0005; bus.id_imm16 = 16'hFFFC;
        bus.id_alusrc = 2'd1; bus.id_aluop = ALU_ADD;
        cycle();
        ncmp++; if (bus.portA !== 32'h5) begin nfail++; $display("FAIL capture_portA got %h want 00000005", bus.portA); end
        ncmp++; if (bus.portB !== 32'hFFFF_FFFC) begin nfail++; $display("FAIL capture_portB got %h want fffffffc", bus.portB); end
        ncmp++; if (bus.aluop !== ALU_ADD) begin nfail++; $display("FAIL capture_aluop got %0d want %0d", bus.aluop, ALU_ADD); end
        ncmp++; if (bus.ex_valid !== 1'b1) begin nfail++; $display("FAIL capture_valid got %b want 1", bus.ex_valid); end
    endtask

    task automatic test_lui_shift();
        drive_random();
        bus.en = 1'b1; bus.flush = 1'b0; bus.id_shift = 1'b0;
        bus.id_alusrc = 2'd3; bus.id_imm16 = 16'h1234;
        cycle();
        ncmp++; if (bus.portB !== 32'h1234_0000) begin nfail++; $display("FAIL lui_portB got %h want 12340000", bus.portB); end
        bus.id_alusrc = 2'd2; bus.id_imm16 = 16'h8001;
        cycle();
        ncmp++; if (bus.portB !== 32'h0000_8001) begin nfail++; $display("FAIL zext_portB got %h want 00008001", bus.portB); end
        bus.id_shift = 1'b1; bus.id_rdat2 = 32'h1; bus.id_shamt = 5'd4;
        bus.id_alusrc = 2'($urandom);
        cycle();
        ncmp++; if (bus.portA !== 32'h1) begin nfail++; $display("FAIL shift_portA got %h want 00000001", bus.portA); end
        ncmp++; if (bus.portB !== 32'h4) begin nfail++; $display("FAIL shift_portB got %h want 00000004", bus.portB); end
    endtask

    task automatic test_stall();
        logic [31:0] a0, b0, s0;
        aluop_t      op0;
        do_reset();
        drive_random();
        bus.en = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b1;
        cycle();
        a0 = exp_a; b0 = exp_b; s0 = exp_stdat; op0 = exp_op;
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            cycle();
        end
        ncmp++; if (bus.portA !== a0 || bus.portB !== b0) begin nfail++; $display("FAIL stall_ports got %h/%h want %h/%h", bus.portA, bus.portB, a0, b0); end
        ncmp++; if (bus.ex_stdat !== s0 || bus.aluop !== op0 || bus.ex_valid !== 1'b1) begin nfail++; $display("FAIL stall_hold got %h/%0d/%b want %h/%0d/1", bus.ex_stdat, bus.aluop, bus.ex_valid, s0, op0); end
`ifdef ID_EX_PERF_EN
        ncmp++; if (bus.stall_cnt !== 16'd3) begin nfail++; $display("FAIL stall_cnt got %0d want 3", bus.stall_cnt); end
`else
        ncmp++; if (bus.stall_cnt !== 16'd0) begin nfail++; $display("FAIL stall_cnt got %0d want 0", bus.stall_cnt); end
`endif
    endtask

    task automatic test_flush();
        drive_random();
        bus.en = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b1; bus.id_regwen = 1'b1;
        bus.id_aluop = ALU_OR;
        cycle();
        bus.flush = 1'b1; bus.en = 1'b0;
        cycle();
        ncmp++; if (bus.ex_valid !== 1'b0 || bus.ex_regwen !== 1'b0) begin nfail++; $display("FAIL flush_ctl got %b/%b want 0/0", bus.ex_valid, bus.ex_regwen); end
        ncmp++; if (bus.aluop !== ALU_SLL) begin nfail++; $display("FAIL flush_aluop got %0d want %0d", bus.aluop, ALU_SLL); end
        ncmp++; if (bus.portA !== 0 || bus.portB !== 0 || bus.ex_stdat !== 0 || bus.ex_wsel !== 0) begin nfail++; $display("FAIL flush_data got %h/%h/%h/%h want zeros", bus.portA, bus.portB, bus.ex_stdat, bus.ex_wsel); end
        bus.flush = 1'b0;
    endtask

    task automatic test_bubble();
        drive_random();
        bus.en = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b0; bus.id_regwen = 1'b1;
        cycle();
        ncmp++; if (bus.ex_valid !== 1'b0 || bus.ex_regwen !== 1'b0) begin nfail++; $display("FAIL bubble got %b/%b want 0/0", bus.ex_valid, bus.ex_regwen); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_random();
            bus.en    = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            cycle();
            ncmp++;
            if (bus.portA !== exp_a || bus.portB !== exp_b || bus.ex_stdat !== exp_stdat ||
                bus.aluop !== exp_op || bus.ex_valid !== exp_valid ||
                bus.ex_regwen !== exp_regwen || bus.ex_wsel !== exp_wsel ||
                bus.stall_cnt !== 16'(exp_cnt)) begin
                nfail++;
                $display("FAIL random[%0d] got A=%h B=%h S=%h op=%0d v=%b w=%b ws=%h c=%0d want A=%h B=%h S=%h op=%0d v=%b w=%b ws=%h c=%0d",
                         i, bus.portA, bus.portB, bus.ex_stdat, bus.aluop, bus.ex_valid, bus.ex_regwen, bus.ex_wsel, bus.stall_cnt,
                         exp_a, exp_b, exp_stdat, exp_op, exp_valid, exp_regwen, exp_wsel, exp_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_random();
        bus.en = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b1; bus.id_regwen = 1'b1;
        bus.id_alusrc = 2'd0; bus.id_shift = 1'b0; bus.id_rdat1 = 32'hDEAD_BEEF;
        cycle();
        bus.en = 1'b0;
        cycle();
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        ncmp++; if (bus.portA !== 0 || bus.portB !== 0 || bus.ex_stdat !== 0) begin nfail++; $display("FAIL areset_data got %h/%h/%h want zeros", bus.portA, bus.portB, bus.ex_stdat); end
        ncmp++; if (bus.aluop !== ALU_SLL || bus.ex_valid !== 0 || bus.ex_regwen !== 0 || bus.ex_wsel !== 0 || bus.stall_cnt !== 0) begin nfail++; $display("FAIL areset_ctl got %0d/%b/%b/%h/%0d want SLL/0/0/0/0", bus.aluop, bus.ex_valid, bus.ex_regwen, bus.ex_wsel, bus.stall_cnt); end
        @(negedge CLK);
        nRST = 1'b1;
        drive_random();
        bus.en = 1'b1; bus.id_valid = 1'b1; bus.id_shift = 1'b0; bus.id_alusrc = 2'd2;
        bus.id_rdat1 = 32'h0000_00A5; bus.id_imm16 = 16'h00FF;
        cycle();
        ncmp++; if (bus.portA !== 32'hA5 || bus.portB !== 32'hFF || bus.ex_valid !== 1'b1) begin nfail++; $display("FAIL areset_recapture got %h/%h/%b want 000000a5/000000ff/1", bus.portA, bus.portB, bus.ex_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive_random();
        bus.en = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b1;
        cycle();
        bus.en = 1'b0;
        repeat (65534) @(posedge CLK);
        @(negedge CLK);
`ifdef ID_EX_PERF_EN
        exp_cnt = 65534;
`endif
        ncmp++; if (bus.stall_cnt !== 16'(exp_cnt)) begin nfail++; $display("FAIL sat_pre got %0d want %0d", bus.stall_cnt, exp_cnt); end
        repeat (6) @(posedge CLK);
        @(negedge CLK);
`ifdef ID_EX_PERF_EN
        exp_cnt = 65535;
`endif
        ncmp++; if (bus.stall_cnt !== 16'(exp_cnt)) begin nfail++; $display("FAIL sat_hold got %0d want %0d", bus.stall_cnt, exp_cnt); end
        ncmp++; if (bus.ex_valid !== 1'b1 || bus.portA !== exp_a) begin nfail++; $display("FAIL sat_state got %b/%h want 1/%h", bus.ex_valid, bus.portA, exp_a); end
    endtask

    initial begin
        ncmp = 0;
        nfail = 0;
        test_reset();
        test_capture();
        test_lui_shift();
        test_stall();
        test_flush();
        test_bubble();
        test_random();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
